// File: rtl/ks_memory_pkg.sv
// Shared types and default sizes for the K&S unified instruction/data RAM.
package ks_memory_pkg;
  localparam int KS_ADDR_W = 5;
  localparam int KS_DATA_W = 16;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN} mem_state_type;
endpackage

// File: rtl/ks_memory_if.sv
// CPU data-path port, program-load port and status lines of ks_memory.
interface ks_memory_if
  import ks_memory_pkg::*;
#(
  parameter int ADDR_W = KS_ADDR_W,
  parameter int DATA_W = KS_DATA_W
);
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              ram_write_enable;
  logic [DATA_W-1:0] ram_rdata;
  logic              load_start;
  logic              load_valid;
  logic [DATA_W-1:0] load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  logic              cpu_rst_n;
  logic              busy;

  modport master (
    output ram_addr, cpu_wdata, ram_write_enable,
    output load_start, load_valid, load_data, load_last,
    input  ram_rdata, load_ready, load_done, cpu_rst_n, busy
  );

  modport slave (
    input  ram_addr, cpu_wdata, ram_write_enable,
    input  load_start, load_valid, load_data, load_last,
    output ram_rdata, load_ready, load_done, cpu_rst_n, busy
  );
endinterface

// File: rtl/ks_memory_ram_1p.sv
// Single-port RAM with read-first registered output; contents clear on reset.
module ks_ram_1p
  import ks_memory_pkg::*;
#(
  parameter int ADDR_W = KS_ADDR_W,
  parameter int DATA_W = KS_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_re,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);
  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [DATA_W-1:0] r_rdata;

  // Read and write sample the same pre-edge array, giving old data on a collision.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rdata <= '0;
    end else begin
      if (i_re) r_rdata <= r_mem[i_addr];
      if (i_we) r_mem[i_addr] <= i_wdata;
    end
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/ks_memory.sv
// Unified 32x16 K&S RAM: loads a program image while holding the CPU in reset, then serves it.
module ks_memory
  import ks_memory_pkg::*;
#(
  parameter int ADDR_W     = KS_ADDR_W,
  parameter int DATA_W     = KS_DATA_W,
  parameter int LOAD_WORDS = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  ks_memory_if.slave io_bus
);
  localparam int CW = ADDR_W + 1;

  mem_state_type     r_state, w_next;
  logic [CW-1:0]     r_cnt, w_cnt_next;
  logic              r_cpu_rst_n, r_busy, r_load_ready, r_load_done;
  logic              w_cpu_rst_n_nxt, w_busy_nxt, w_load_ready_nxt, w_load_done_nxt;
  logic              w_xfer, w_last_word;
  logic              w_ram_re, w_ram_we;
  logic [ADDR_W-1:0] w_ram_addr;
  logic [DATA_W-1:0] w_ram_wdata;

  assign w_xfer      = (r_state == S_LOAD) && io_bus.load_valid && r_load_ready;
  assign w_last_word = (r_cnt == CW'(LOAD_WORDS - 1)) || io_bus.load_last;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_cpu_rst_n  <= 1'b0;
      r_busy       <= 1'b0;
      r_load_ready <= 1'b0;
      r_load_done  <= 1'b0;
    end else begin
      r_state      <= w_next;
      r_cnt        <= w_cnt_next;
      r_cpu_rst_n  <= w_cpu_rst_n_nxt;
      r_busy       <= w_busy_nxt;
      r_load_ready <= w_load_ready_nxt;
      r_load_done  <= w_load_done_nxt;
    end
  end

  // Counter returns to 0 on the last word so it never leaves the image range.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    case (r_state)
      S_IDLE: if (io_bus.load_start) begin
        w_next     = S_LOAD;
        w_cnt_next = '0;
      end
      S_LOAD: if (w_xfer) begin
        if (w_last_word) begin
          w_next     = S_RUN;
          w_cnt_next = '0;
        end else begin
          w_cnt_next = r_cnt + 1'b1;
        end
      end
      S_RUN: if (io_bus.load_start) begin
        w_next     = S_LOAD;
        w_cnt_next = '0;
      end
      default: begin
        w_next     = S_IDLE;
        w_cnt_next = '0;
      end
    endcase
  end

  // Status outputs are decoded from the next state so they flip on the state edge.
  always_comb begin
    w_cpu_rst_n_nxt  = (w_next == S_RUN);
    w_busy_nxt       = (w_next == S_LOAD);
    w_load_ready_nxt = (w_next == S_LOAD);
    w_load_done_nxt  = w_xfer && w_last_word;
    w_ram_re         = (r_state == S_RUN);
    w_ram_we         = 1'b0;
    w_ram_addr       = io_bus.ram_addr;
    w_ram_wdata      = io_bus.cpu_wdata;
    if (r_state == S_LOAD) begin
      w_ram_we    = w_xfer;
      w_ram_addr  = r_cnt[ADDR_W-1:0];
      w_ram_wdata = io_bus.load_data;
    end else if (r_state == S_RUN) begin
      w_ram_we = io_bus.ram_write_enable;
    end
  end

  ks_ram_1p #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_re    (w_ram_re),
    .i_we    (w_ram_we),
    .i_addr  (w_ram_addr),
    .i_wdata (w_ram_wdata),
    .o_rdata (io_bus.ram_rdata)
  );

  assign io_bus.cpu_rst_n  = r_cpu_rst_n;
  assign io_bus.busy       = r_busy;
  assign io_bus.load_ready = r_load_ready;
  assign io_bus.load_done  = r_load_done;
endmodule

// File: tb/tb_ks_memory.sv
// Randomized bench for ks_memory against a behavioural model, plus directed literal checks.
module tb_ks_memory;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  bit   chk_en = 1'b0;
  int   vecs = 0;
  int   errs = 0;

  always #5 clk = ~clk;

  ks_memory_if #(.ADDR_W(5), .DATA_W(16)) bus ();

  ks_memory #(.ADDR_W(5), .DATA_W(16), .LOAD_WORDS(32)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  // Model: mode flags and an array, advanced once per rising edge.
  bit          m_load, m_run, m_done;
  int          m_cnt;
  logic [15:0] m_mem [32];
  logic [15:0] m_rdata;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_load = 0; m_run = 0; m_done = 0; m_cnt = 0; m_rdata = 16'h0;
      for (int i = 0; i < 32; i++) m_mem[i] = 16'h0;
    end else begin
      m_done = 0;
      if (m_run) begin
        m_rdata = m_mem[bus.ram_addr];
        if (bus.ram_write_enable) m_mem[bus.ram_addr] = bus.cpu_wdata;
        if (bus.load_start) begin m_run = 0; m_load = 1; m_cnt = 0; end
      end else if (m_load) begin
        if (bus.load_valid) begin
          m_mem[m_cnt] = bus.load_data;
          if (m_cnt == 31 || bus.load_last) begin
            m_load = 0; m_run = 1; m_done = 1; m_cnt = 0;
          end else m_cnt++;
        end
      end else if (bus.load_start) begin
        m_load = 1; m_cnt = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && chk_en) begin
      chk("m_rdata",      bus.ram_rdata,         m_rdata);
      chk("m_cpu_rst_n",  16'(bus.cpu_rst_n),    16'(m_run));
      chk("m_busy",       16'(bus.busy),         16'(m_load));
      chk("m_load_ready", 16'(bus.load_ready),   16'(m_load));
      chk("m_load_done",  16'(bus.load_done),    16'(m_done));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ram_addr = '0; bus.cpu_wdata = '0; bus.ram_write_enable = 0;
    bus.load_start = 0; bus.load_valid = 0; bus.load_data = '0; bus.load_last = 0;
  endtask

  task automatic rd(input int a, input logic [15:0] exp, input string name);
    bus.ram_addr = 5'(a);
    tick();
    chk(name, bus.ram_rdata, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rdata"},  bus.ram_rdata,       16'h0);
    chk({tag, "_cpurst"}, 16'(bus.cpu_rst_n),  16'h0);
    chk({tag, "_ready"},  16'(bus.load_ready), 16'h0);
    chk({tag, "_busy"},   16'(bus.busy),       16'h0);
    chk({tag, "_done"},   16'(bus.load_done),  16'h0);
  endtask

  initial begin
    idle_inputs();
    #1 rst_n = 1'b0;
    #1 chk_reset_vals("rst_async");
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;
    chk_en = 1'b1;

    // IDLE: CPU writes and load words must both be ignored.
    bus.ram_write_enable = 1; bus.ram_addr = 5'd3; bus.cpu_wdata = 16'hFFFF;
    bus.load_valid = 1; bus.load_data = 16'h5555;
    repeat (5) tick();
    idle_inputs();

    // Short load with stalls, load_last on the third word.
    bus.load_start = 1; tick(); bus.load_start = 0;
    begin
      int i = 0;
      int k = 0;
      while (i < 3) begin
        if (k % 2 == 0) begin
          bus.load_valid = 1; bus.load_data = 16'hA001 + 16'(i); bus.load_last = (i == 2);
          i++;
        end else begin
          bus.load_valid = 0; bus.load_last = 0;
        end
        tick();
        k++;
      end
    end
    idle_inputs();
    chk("short_done", 16'(bus.load_done), 16'h1);
    chk("short_cpurst", 16'(bus.cpu_rst_n), 16'h1);
    rd(0, 16'hA001, "short_rd0");
    rd(1, 16'hA002, "short_rd1");
    rd(2, 16'hA003, "short_rd2");
    rd(3, 16'h0000, "short_rd3");

    // Full 32-word load started from RUN.
    bus.load_start = 1; tick(); bus.load_start = 0;
    chk("full_cpurst_low", 16'(bus.cpu_rst_n), 16'h0);
    for (int i = 0; i < 32; i++) begin
      bus.load_valid = 1; bus.load_data = 16'h8000 + 16'(i);
      tick();
    end
    idle_inputs();
    chk("full_done", 16'(bus.load_done), 16'h1);
    chk("full_cpurst", 16'(bus.cpu_rst_n), 16'h1);
    tick();
    chk("full_done_once", 16'(bus.load_done), 16'h0);
    for (int i = 0; i < 32; i++) rd(i, 16'h8000 + 16'(i), "full_rd");

    // Read-during-write returns the old word first.
    bus.ram_addr = 5'd7; bus.ram_write_enable = 1; bus.cpu_wdata = 16'h1234;
    tick();
    bus.ram_write_enable = 0;
    chk("rdw_old", bus.ram_rdata, 16'h8007);
    tick();
    chk("rdw_new", bus.ram_rdata, 16'h1234);

    // Reload a 2-word image; word 2 must survive.
    bus.load_start = 1; tick(); bus.load_start = 0;
    chk("reload_cpurst", 16'(bus.cpu_rst_n), 16'h0);
    chk("reload_busy", 16'(bus.busy), 16'h1);
    bus.load_valid = 1; bus.load_data = 16'hBEEF; tick();
    bus.load_data = 16'hCAFE; bus.load_last = 1; tick();
    idle_inputs();
    rd(0, 16'hBEEF, "reload_rd0");
    rd(1, 16'hCAFE, "reload_rd1");
    rd(2, 16'h8002, "reload_rd2");

    // Random traffic on both ports; the model checks every cycle.
    for (int n = 0; n < 1500; n++) begin
      bus.ram_addr         = 5'($urandom_range(0, 31));
      bus.cpu_wdata        = 16'($urandom);
      bus.ram_write_enable = ($urandom_range(0, 2) == 0);
      bus.load_start       = ($urandom_range(0, 39) == 0);
      bus.load_valid       = ($urandom_range(0, 2) != 0);
      bus.load_data        = 16'($urandom);
      bus.load_last        = ($urandom_range(0, 9) == 0);
      tick();
    end
    idle_inputs();

    // Reset in the middle of a load discards everything.
    rst_n = 1'b0; #1 rst_n = 1'b1;
    bus.load_start = 1; tick(); bus.load_start = 0;
    for (int i = 0; i < 10; i++) begin
      bus.load_valid = 1; bus.load_data = 16'h7000 + 16'(i); tick();
    end
    idle_inputs();
    rst_n = 1'b0;
    #1 chk_reset_vals("midload");
    @(posedge clk); #1 rst_n = 1'b1;
    bus.load_start = 1; tick(); bus.load_start = 0;
    bus.load_valid = 1; bus.load_data = 16'h0000; bus.load_last = 1; tick();
    idle_inputs();
    chk("midload_done", 16'(bus.load_done), 16'h1);
    for (int i = 0; i < 32; i++) rd(i, 16'h0000, "midload_rd");

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/ks_memory.md
Name: ks_memory

Overview:
- Unified 32x16 instruction/data RAM that answers the K&S processor data path.
- On the CPU side it receives the address and write data and returns read data.
- Before execution, it also accepts a program image over a valid/ready load port.
- It holds the CPU in reset until loading completes, then serves CPU reads and writes.

Parameters:
ADDR_W, 5, address width; depth = 2**ADDR_W words
DATA_W, 16, word width
LOAD_WORDS, 32, words loaded before automatic switch to RUN; legal range 1..2**ADDR_W

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
ram_addr  input  ADDR_W  CPU word address
cpu_wdata  input  DATA_W  CPU write data (data path data_out)
ram_write_enable  input  1  CPU write strobe
ram_rdata  output  DATA_W  registered read data (data path data_in)
load_start  input  1  begin/restart program load
load_valid  input  1  load word present
load_data  input  DATA_W  load word
load_last  input  1  qualifies final word of a short image
load_ready  output  1  block accepts load word this cycle
load_done  output  1  one-cycle pulse when load completes
cpu_rst_n  output  1  active-low reset to CPU core
busy  output  1  high in LOAD

Behaviour:
- The single clock is clk. Reset is rst_n, which is asynchronous and active-low. All flops reset asynchronously when rst_n=0.
- Reset values:
  - state=IDLE, load counter=0.
  - ram_rdata=0, load_ready=0, load_done=0, cpu_rst_n=0, busy=0.
  - All memory words cleared to 16'h0000.
- States:
  - IDLE: cpu_rst_n=0, load_ready=0. load_start=1 -> LOAD, counter=0.
  - LOAD: busy=1, load_ready=1, cpu_rst_n=0.
    - A transfer occurs when load_valid&&load_ready: mem[counter]<=load_data, counter<=counter+1.
    - If the transfer has counter==LOAD_WORDS-1 or load_last=1 -> RUN; load_done=1 in the following cycle only.
    - load_valid=0 leaves state and counter unchanged.
    - load_start in LOAD is ignored.
  - RUN: cpu_rst_n=1, load_ready=0, busy=0.
    - Read: ram_rdata<=mem[ram_addr] every cycle (1-cycle latency).
    - Write: ram_write_enable=1 -> mem[ram_addr]<=cpu_wdata at the edge.
    - load_start=1 -> LOAD, counter=0, cpu_rst_n=0 from the next cycle. Memory is not cleared, so words beyond the new image keep old contents.
- Registered outputs: cpu_rst_n, busy and load_ready are registered, decoded from next state, so they change on the edge that changes state.
- CPU port outside RUN: ram_write_enable is ignored and ram_rdata holds its last value.
- Read-during-write, same address in RUN: ram_rdata returns the old word (read-first). The new word is visible on the next read.
- Load port in RUN/IDLE: load_valid is ignored; no write occurs.
- Counter: width ADDR_W+1 and never exceeds LOAD_WORDS-1 when written. It does not wrap, because the switch to RUN happens on the last word.
- Reset mid-load: returns to IDLE immediately and clears memory. A partial image is discarded.
- Simultaneous load_start and ram_write_enable in RUN: the CPU write is performed in that cycle, and the state moves to LOAD.

Decomposition:
- k_and_s_pkg additions:
  - typedef enum mem_state_type {S_IDLE, S_LOAD, S_RUN}.
  - Constants KS_ADDR_W=5, KS_DATA_W=16.
- One natural sub-module: ks_ram_1p. It holds the single-port array with registered read-first output and a write enable. ks_memory muxes its address/data/write-enable between the loader (LOAD) and the CPU (RUN).

Test Plan:
- Reset: after reset release, ram_rdata=0, cpu_rst_n=0, load_ready=0, busy=0. Then wait 5 cycles in IDLE with ram_write_enable=1, addr=3 -> later readback of mem[3] is 0.
- Full load: load_start, then 32 words 16'h8000+i with load_valid held -> load_done pulses once on the cycle after word 31, and cpu_rst_n=1 that same cycle. Reads of addr 0..31 return 16'h8000+i one cycle after the address.
- Short load with stalls:
  - Stimulus: 3 words A001/A002/A003, load_last on the third, load_valid toggled 1/0.
  - Response: exactly 3 writes, RUN entered, addr 3 reads 0.
- CPU write/read, read-during-write: in RUN, write 16'h1234 to addr 7. The same-cycle read of addr 7 returns the old value; the next cycle returns 16'h1234.
- Reload from RUN: load_start with a 2-word image 0xBEEF,0xCAFE (load_last on second) -> cpu_rst_n low during LOAD. Afterwards addr 0/1 read BEEF/CAFE, and addr 2 keeps its earlier value.
- Reset mid-load: assert rst_n=0 after 10 words -> outputs go to reset values immediately, and all addresses read 0 after a subsequent full load of zeros is skipped (load_last on first word 0).
